// File: rtl/dram_ctrl_pkg.sv
// Shared configuration and types for the DRAM window controller.
package dram_ctrl_pkg;

    // RAM depth in address bits; the RAM holds 2**dram_depth 32-bit words.
    localparam int dram_depth = 6;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // Request register: everything ACCESS/RESP need, captured when the request is taken.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        hit;
    } req_t;

    // Window test with 32-bit wrap-around arithmetic, so addresses below the base miss too.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] offset;
        offset = addr - base;
        return offset < (32'd4 << dram_depth);
    endfunction

endpackage

// File: rtl/dram_ctrl.sv
// Single-port request front end for a word-addressed RAM with registered reads.
// Optionally zero-fills the RAM after reset; requests arriving meanwhile are held.
module dram_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter bit          CLEAR_ON_RESET = 1'b0,
    parameter logic [31:0] DRAM_BASE      = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  mem_error,
    output logic                  dram_wen,
    output logic [dram_depth-1:0] dram_waddr,
    output logic [dram_depth-1:0] dram_raddr,
    output logic [31:0]           dram_wdata,
    output logic [3:0]            dram_wstrb,
    input  logic [31:0]           dram_rdata
);

    localparam state_e                RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;
    localparam logic [dram_depth-1:0] LAST_IDX    = {dram_depth{1'b1}};

    state_e                state_q, state_d;
    req_t                  req_q, req_d;
    logic                  pend_q, pend_d;
    logic [dram_depth-1:0] cnt_q, cnt_d;
    // Low for the first cycle out of reset so CLEAR outputs stay quiet while rst is asserted.
    logic                  armed_q, armed_d;

    logic [dram_depth-1:0] req_idx;
    logic                  req_write;
    logic                  unused_addr_bits;

    assign req_idx          = req_q.addr[dram_depth+1:2];
    assign req_write        = |req_q.wstrb;
    assign unused_addr_bits = ^{req_q.addr[31:dram_depth+2], req_q.addr[1:0]};

    // State, request register, clear counter and arming flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RESET_STATE;
            req_q   <= '0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    // Next-state logic: request capture, clear sequencing, fixed two-cycle service.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        armed_d = 1'b1;
        unique case (state_q)
            CLEAR: begin
                // Only the first request during the fill is kept; later pulses violate the protocol.
                if (mem_valid && !pend_q) begin
                    req_d.addr  = mem_addr;
                    req_d.wdata = mem_wdata;
                    req_d.wstrb = mem_wstrb;
                    req_d.hit   = in_window(mem_addr, DRAM_BASE);
                    pend_d      = 1'b1;
                end
                if (armed_q) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = (pend_q || mem_valid) ? ACCESS : IDLE;
                        pend_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            IDLE: begin
                if (mem_valid) begin
                    req_d.addr  = mem_addr;
                    req_d.wdata = mem_wdata;
                    req_d.wstrb = mem_wstrb;
                    req_d.hit   = in_window(mem_addr, DRAM_BASE);
                    state_d     = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs: RAM port driven only in CLEAR and ACCESS, response only in RESP.
    always_comb begin
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        mem_error  = 1'b0;
        dram_wen   = 1'b0;
        dram_waddr = '0;
        dram_raddr = '0;
        dram_wdata = '0;
        dram_wstrb = '0;
        unique case (state_q)
            CLEAR: begin
                if (armed_q) begin
                    dram_wen   = 1'b1;
                    dram_waddr = cnt_q;
                    dram_wstrb = 4'hF;
                end
            end
            ACCESS: begin
                if (req_q.hit) begin
                    if (req_write) begin
                        dram_wen   = 1'b1;
                        dram_waddr = req_idx;
                        dram_wdata = req_q.wdata;
                        dram_wstrb = req_q.wstrb;
                    end else begin
                        dram_raddr = req_idx;
                    end
                end
            end
            RESP: begin
                mem_ready = 1'b1;
                mem_error = !req_q.hit;
                if (req_q.hit && !req_write) begin
                    mem_rdata = dram_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: table vectors, randomized traffic against a word-array model,
// reset during ACCESS, and the post-reset zero fill with a request held across it.
module tb_dram_ctrl;

    localparam int          DEPTH = dram_ctrl_pkg::dram_depth;
    localparam int          WORDS = 2 ** DEPTH;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: no clear on reset
    logic             rst0 = 1'b0, valid0 = 1'b0;
    logic [31:0]      addr0 = '0, wdata0 = '0;
    logic [3:0]       wstrb0 = '0;
    logic             mem_ready0, mem_error0, dram_wen0;
    logic [31:0]      mem_rdata0, dram_wdata0;
    logic [31:0]      dram_rdata0 = '0;
    logic [DEPTH-1:0] dram_waddr0, dram_raddr0;
    logic [3:0]       dram_wstrb0;
    logic [31:0]      ram0 [WORDS] = '{default: 32'h0};

    // Instance 1: zero fill on reset
    logic             rst1 = 1'b0, valid1 = 1'b0;
    logic [31:0]      addr1 = '0, wdata1 = '0;
    logic [3:0]       wstrb1 = '0;
    logic             mem_ready1, mem_error1, dram_wen1;
    logic [31:0]      mem_rdata1, dram_wdata1;
    logic [31:0]      dram_rdata1 = '0;
    logic [DEPTH-1:0] dram_waddr1, dram_raddr1;
    logic [3:0]       dram_wstrb1;
    logic [31:0]      ram1 [WORDS] = '{default: 32'hFFFF_FFFF};

    dram_ctrl #(.CLEAR_ON_RESET(1'b0), .DRAM_BASE(BASE)) u0 (
        .clk(clk), .rst(rst0), .mem_valid(valid0), .mem_addr(addr0), .mem_wdata(wdata0),
        .mem_wstrb(wstrb0), .mem_ready(mem_ready0), .mem_rdata(mem_rdata0), .mem_error(mem_error0),
        .dram_wen(dram_wen0), .dram_waddr(dram_waddr0), .dram_raddr(dram_raddr0),
        .dram_wdata(dram_wdata0), .dram_wstrb(dram_wstrb0), .dram_rdata(dram_rdata0)
    );

    dram_ctrl #(.CLEAR_ON_RESET(1'b1), .DRAM_BASE(BASE)) u1 (
        .clk(clk), .rst(rst1), .mem_valid(valid1), .mem_addr(addr1), .mem_wdata(wdata1),
        .mem_wstrb(wstrb1), .mem_ready(mem_ready1), .mem_rdata(mem_rdata1), .mem_error(mem_error1),
        .dram_wen(dram_wen1), .dram_waddr(dram_waddr1), .dram_raddr(dram_raddr1),
        .dram_wdata(dram_wdata1), .dram_wstrb(dram_wstrb1), .dram_rdata(dram_rdata1)
    );

    // Byte-enabled RAMs with one-cycle registered read
    always @(posedge clk) begin
        if (dram_wen0)
            for (int b = 0; b < 4; b++)
                if (dram_wstrb0[b]) ram0[dram_waddr0][8*b +: 8] <= dram_wdata0[8*b +: 8];
        dram_rdata0 <= ram0[dram_raddr0];
    end

    always @(posedge clk) begin
        if (dram_wen1)
            for (int b = 0; b < 4; b++)
                if (dram_wstrb1[b]) ram1[dram_waddr1][8*b +: 8] <= dram_wdata1[8*b +: 8];
        dram_rdata1 <= ram1[dram_raddr1];
    end

    int total = 0;
    int bad   = 0;
    logic [31:0] model [WORDS];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: the RAM is a plain word array; the window is a byte range above BASE.
    task automatic model_apply(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                               output logic [31:0] rd, output logic er);
        int idx;
        idx = int'((a >> 2) % WORDS);
        er  = (a - BASE) >= 32'(4 * WORDS);
        rd  = '0;
        if (!er) begin
            if (ws == 4'h0) rd = model[idx];
            else
                for (int b = 0; b < 4; b++)
                    if (ws[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    // One request on instance 0; checks the ACCESS cycle, the RESP cycle at T+2 and the idle cycle after.
    task automatic run0(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] exp_rd, input logic exp_er,
                        input bit inject);
        logic exp_wen;
        logic [31:0] idx;
        exp_wen = (ws != 4'h0) && !exp_er;
        idx     = (a >> 2) % WORDS;
        @(posedge clk); #1;
        valid0 = 1'b1; addr0 = a; wdata0 = wd; wstrb0 = ws;
        @(posedge clk); #1;
        valid0 = 1'b0; addr0 = $urandom; wdata0 = $urandom; wstrb0 = 4'($urandom);
        check({tag, " access ready"}, 32'(mem_ready0), 32'h0);
        check({tag, " access wen"}, 32'(dram_wen0), 32'(exp_wen));
        if (exp_wen) begin
            check({tag, " waddr"}, 32'(dram_waddr0), idx);
            check({tag, " wdata"}, dram_wdata0, wd);
            check({tag, " wstrb"}, 32'(dram_wstrb0), 32'(ws));
        end else if (!exp_er) begin
            check({tag, " raddr"}, 32'(dram_raddr0), idx);
        end
        if (inject) begin
            valid0 = 1'b1; wstrb0 = 4'hF; addr0 = 32'($urandom_range(0, 4 * WORDS - 1));
        end
        @(posedge clk); #1;
        check({tag, " ready"}, 32'(mem_ready0), 32'h1);
        check({tag, " rdata"}, mem_rdata0, exp_rd);
        check({tag, " error"}, 32'(mem_error0), 32'(exp_er));
        check({tag, " resp ram port"}, {dram_wdata0[23:0], 32'(dram_wen0) | 32'(dram_waddr0) | 32'(dram_raddr0) | 32'(dram_wstrb0)} , 32'h0 | {dram_wdata0[23:0], 8'h0});
        if (inject) valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        check({tag, " idle ready"}, 32'(mem_ready0), 32'h0);
        check({tag, " idle wen"}, 32'(dram_wen0), 32'h0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [31:0] rd, a, wd;
        logic        er, rdy_err;
        logic [3:0]  ws;
        int nw, seq_bad, nrdy, last_k, rdy_k, nz;

        for (int i = 0; i < WORDS; i++) model[i] = '0;

        tbl[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        tbl[1]  = '{32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0,         1'b0};
        tbl[3]  = '{32'h0000_0010, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
        tbl[4]  = '{32'h0000_0013, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
        tbl[5]  = '{32'h0000_00FC, 32'hA5A5_5A5A, 4'hF, 32'h0,         1'b0};
        tbl[6]  = '{32'h0000_00FF, 32'h0,         4'h0, 32'hA5A5_5A5A, 1'b0};
        tbl[7]  = '{BASE + 32'(4 * WORDS), 32'h0, 4'h0, 32'h0,         1'b1};
        tbl[8]  = '{BASE + 32'(4 * WORDS), 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
        tbl[9]  = '{32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 32'h0,         1'b1};
        tbl[10] = '{32'h0000_0000, 32'h0,         4'h0, 32'h0,         1'b0};

        // Reset state for both instances
        #3;
        check("rst ready0", 32'(mem_ready0), 32'h0);
        check("rst wen0", 32'(dram_wen0), 32'h0);
        check("rst rdata0", mem_rdata0, 32'h0);
        check("rst ready1", 32'(mem_ready1), 32'h0);
        check("rst wen1", 32'(dram_wen1), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst0 = 1'b1;
        @(posedge clk); #1;
        check("idle wen0", 32'(dram_wen0), 32'h0);
        check("idle ready0", 32'(mem_ready0), 32'h0);

        // Table vectors
        for (int i = 0; i < 11; i++) begin
            run0($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wdata, tbl[i].wstrb,
                 tbl[i].exp_rdata, tbl[i].exp_err, 1'b0);
            model_apply(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, rd, er);
            if (i == 0) check("ram word 4", ram0[4], 32'hDEAD_BEEF);
        end

        // Randomized traffic, with occasional protocol-violating pulses in ACCESS/RESP
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 4 * WORDS + 63));
            wd = $urandom;
            ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            model_apply(a, wd, ws, rd, er);
            run0($sformatf("rnd%0d", n), a, wd, ws, rd, er, $urandom_range(0, 3) == 0);
        end

        // Reset during ACCESS of a write: dropped, no response, wen falls at once
        @(posedge clk); #1;
        valid0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h1234_5678; wstrb0 = 4'hF;
        @(posedge clk); #1;
        valid0 = 1'b0;
        check("mid wen before rst", 32'(dram_wen0), 32'h1);
        #1 rst0 = 1'b0;
        #1;
        check("mid wen async", 32'(dram_wen0), 32'h0);
        check("mid ready async", 32'(mem_ready0), 32'h0);
        rdy_err = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_ready0) rdy_err = 1'b1;
        end
        check("mid no ready", 32'(rdy_err), 32'h0);
        @(negedge clk) rst0 = 1'b1;
        check("mid ram untouched", ram0[8], model[8]);
        model_apply(32'h20, 32'h0, 4'h0, rd, er);
        run0("post rst read", 32'h20, 32'h0, 4'h0, rd, er, 1'b0);
        model_apply(32'h24, 32'hCAFE_F00D, 4'hF, rd, er);
        run0("post rst write", 32'h24, 32'hCAFE_F00D, 4'hF, rd, er, 1'b0);
        check("post rst ram", ram0[9], 32'hCAFE_F00D);

        // Zero fill: start, interrupt with reset, then a full fill with a read held across it
        @(posedge clk); #1 rst1 = 1'b1;
        repeat (10) @(posedge clk);
        #2 rst1 = 1'b0;
        #1 check("clear rst wen async", 32'(dram_wen1), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst1 = 1'b1;
        nw = 0; seq_bad = 0; nrdy = 0; last_k = -1; rdy_k = -1; rd = '1; rdy_err = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dram_wen1) begin
                if (32'(dram_waddr1) != 32'(nw) || dram_wdata1 != 32'h0 || dram_wstrb1 != 4'hF)
                    seq_bad++;
                nw++;
                last_k = k;
            end
            if (mem_ready1) begin
                nrdy++; rdy_k = k; rd = mem_rdata1; rdy_err = mem_error1;
            end
            if (valid1) valid1 = 1'b0;
            else if (dram_wen1 && nw == 3) begin
                valid1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h5555_5555; wstrb1 = 4'h0;
            end
        end
        check("clear wen cycles", 32'(nw), 32'(WORDS));
        check("clear sequence errors", 32'(seq_bad), 32'h0);
        check("clear ready count", 32'(nrdy), 32'h1);
        check("clear ready timing", 32'(rdy_k), 32'(last_k + 2));
        check("clear rdata", rd, 32'h0);
        check("clear error", 32'(rdy_err), 32'h0);
        nz = 0;
        for (int i = 0; i < WORDS; i++) if (ram1[i] != 32'h0) nz++;
        check("clear nonzero words", 32'(nz), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
